// File: rtl/inst_ram_loader_if.sv
// Bundle of the boot-loader byte stream, core-release status and instruction fetch port
// for inst_ram_loader. The master side is the byte source and fetching core; the slave side is the loader.
interface inst_ram_loader_if #(
  parameter int N_AW   = 10,
  parameter int N_DATA = 32,
  parameter int N_ADDR = 32
);
  logic              i_ld_start;
  logic              i_ld_vld;
  logic [7:0]        i_ld_byte;
  logic              o_ld_rdy;
  logic              o_core_rst_n;
  logic              o_load_done;
  logic              o_err;
  logic [N_AW:0]     o_word_cnt;
  logic              i_inst_ren;
  logic [N_ADDR-1:0] i_inst_addr;
  logic [N_DATA-1:0] o_inst_data;

  modport master (
    output i_ld_start, i_ld_vld, i_ld_byte, i_inst_ren, i_inst_addr,
    input  o_ld_rdy, o_core_rst_n, o_load_done, o_err, o_word_cnt, o_inst_data
  );

  modport slave (
    input  i_ld_start, i_ld_vld, i_ld_byte, i_inst_ren, i_inst_addr,
    output o_ld_rdy, o_core_rst_n, o_load_done, o_err, o_word_cnt, o_inst_data
  );
endinterface

// File: rtl/inst_ram_loader.sv
// Instruction RAM filled by a big-endian byte-stream boot loader while the core is held in reset;
// the core is released once the declared number of words has been written. Fetch reads are combinational.
module inst_ram_loader #(
  parameter int N_AW   = 10,
  parameter int N_DATA = 32,
  parameter int N_ADDR = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  inst_ram_loader_if.slave ifc
);

  localparam int          DEPTH   = 2**N_AW;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  localparam logic [2:0] S_LEN_HI = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [7:0]        len_hi_r;
  logic [15:0]       len_r;
  logic [15:0]       len_full_s;
  logic [23:0]       asm_r;
  logic [1:0]        byte_idx_r;
  logic [N_AW:0]     word_cnt_r;
  logic [16:0]       cnt_inc_s;
  logic              ld_rdy_r;
  logic              core_rst_n_r;
  logic              load_done_r;
  logic              err_r;
  logic              acc_s;
  logic              word_done_s;
  logic              last_word_s;
  logic [N_DATA-1:0] mem_r [0:DEPTH-1];
  logic [N_AW-1:0]   rd_idx_s;
  logic              rd_ok_s;
  logic [N_DATA-1:0] inst_data_s;
  logic              unused_addr_s;

  // A restart in the same cycle as a valid byte wins, so that byte is never taken.
  assign acc_s       = ifc.i_ld_vld && ld_rdy_r && !ifc.i_ld_start;
  assign len_full_s  = {len_hi_r, ifc.i_ld_byte};
  assign word_done_s = acc_s && (state_r == S_DATA) && (byte_idx_r == 2'd3);
  assign cnt_inc_s   = 17'(word_cnt_r) + 17'd1;
  assign last_word_s = (cnt_inc_s == {1'b0, len_r});

  // Next-state decode of the load sequencer.
  always_comb begin
    state_nxt_s = state_r;
    if (ifc.i_ld_start) begin
      state_nxt_s = S_LEN_HI;
    end else begin
      case (state_r)
        S_LEN_HI: begin
          if (acc_s) state_nxt_s = S_LEN_LO;
          else       state_nxt_s = S_LEN_HI;
        end
        S_LEN_LO: begin
          if (!acc_s)                                state_nxt_s = S_LEN_LO;
          else if (len_full_s == 16'd0)              state_nxt_s = S_RUN;
          else if ({1'b0, len_full_s} > DEPTH_L)     state_nxt_s = S_ERR;
          else                                       state_nxt_s = S_DATA;
        end
        S_DATA: begin
          if (word_done_s && last_word_s) state_nxt_s = S_RUN;
          else                            state_nxt_s = S_DATA;
        end
        S_RUN:   state_nxt_s = S_RUN;
        S_ERR:   state_nxt_s = S_ERR;
        default: state_nxt_s = S_LEN_HI;
      endcase
    end
  end

  // Sequencer state, length/assembly registers and status outputs registered from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= S_LEN_HI;
      len_hi_r     <= 8'd0;
      len_r        <= 16'd0;
      asm_r        <= 24'd0;
      byte_idx_r   <= 2'd0;
      word_cnt_r   <= {(N_AW+1){1'b0}};
      ld_rdy_r     <= 1'b1;
      core_rst_n_r <= 1'b0;
      load_done_r  <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ld_rdy_r     <= (state_nxt_s == S_LEN_HI) || (state_nxt_s == S_LEN_LO) ||
                      (state_nxt_s == S_DATA);
      core_rst_n_r <= (state_nxt_s == S_RUN);
      err_r        <= (state_nxt_s == S_ERR);
      load_done_r  <= (state_nxt_s == S_RUN) && (state_r != S_RUN);
      if (ifc.i_ld_start) begin
        len_hi_r   <= 8'd0;
        len_r      <= 16'd0;
        asm_r      <= 24'd0;
        byte_idx_r <= 2'd0;
        word_cnt_r <= {(N_AW+1){1'b0}};
      end else if (acc_s) begin
        case (state_r)
          S_LEN_HI: len_hi_r <= ifc.i_ld_byte;
          S_LEN_LO: len_r    <= len_full_s;
          S_DATA: begin
            asm_r      <= {asm_r[15:0], ifc.i_ld_byte};
            byte_idx_r <= byte_idx_r + 2'd1;
            if (byte_idx_r == 2'd3) begin
              word_cnt_r <= word_cnt_r + {{N_AW{1'b0}}, 1'b1};
            end
          end
          default: len_hi_r <= len_hi_r;
        endcase
      end
    end
  end

  // RAM write port: only completed words are stored, and never on a reset edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst && word_done_s) begin
      mem_r[word_cnt_r[N_AW-1:0]] <= {asm_r, ifc.i_ld_byte};
    end
  end

  // Byte offset bits are irrelevant to a word fetch.
  assign unused_addr_s = ^ifc.i_inst_addr[1:0];
  assign rd_idx_s      = ifc.i_inst_addr[N_AW+1:2];
  assign rd_ok_s       = ifc.i_inst_ren && (state_r == S_RUN) &&
                         (ifc.i_inst_addr[N_ADDR-1:N_AW+2] == {(N_ADDR-N_AW-2){1'b0}});

  // Combinational fetch; anything outside a valid running fetch reads as all-zero.
  always_comb begin
    if (rd_ok_s) begin
      inst_data_s = mem_r[rd_idx_s];
    end else begin
      inst_data_s = {N_DATA{1'b0}};
    end
  end

  assign ifc.o_ld_rdy     = ld_rdy_r;
  assign ifc.o_core_rst_n = core_rst_n_r;
  assign ifc.o_load_done  = load_done_r;
  assign ifc.o_err        = err_r;
  assign ifc.o_word_cnt   = word_cnt_r;
  assign ifc.o_inst_data  = inst_data_s;

endmodule
